// File: rtl/ks_chunk_add_seq.sv
// ks_chunk_add_seq: W-bit adder that reuses one N-bit Kogge-Stone slice, one chunk per cycle, LSB first.
// Defining KSA_SEQ_FLAGS_EN adds registered zero/ovf result flags.
module ks_chunk_add_seq #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
`ifdef KSA_SEQ_FLAGS_EN
  ,
  output logic         zero_o,
  output logic         ovf_o
`endif
);
  localparam int CHUNKS = W / N;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int LVL    = $clog2(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (N < 2 || (W % N) != 0) begin : g_bad_cfg
    $error("ks_chunk_add_seq: need N >= 2 and W %% N == 0");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] idx_q;
  logic          carry_q, cout_q;
  logic [W-1:0]  a_q, b_q, sum_q, sum_d;
  logic          last;

  assign last        = (idx_q == CW'(CHUNKS - 1));
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;

  // Operand chunk selected by the current index
  logic [N-1:0] ca, cb;
  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < CHUNKS; k++)
      if (idx_q == CW'(k)) begin
        ca = a_q[k*N +: N];
        cb = b_q[k*N +: N];
      end
  end

  // Carry register is folded into bit 0's generate, so gl[LVL][i] is the carry out of bit i.
  logic [LVL:0][N-1:0] gl, pl;
  assign gl[0] = (ca & cb) | {{(N-1){1'b0}}, (ca[0] ^ cb[0]) & carry_q};
  assign pl[0] = ca ^ cb;

  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-D]);
        assign pl[l+1][i] = pl[l][i] & pl[l][i-D];
      end else begin : g_pass
        assign gl[l+1][i] = gl[l][i];
        assign pl[l+1][i] = pl[l][i];
      end
    end
  end

  logic [N-1:0] c, s;
  logic         unused_pl;
  assign c         = gl[LVL];
  assign s         = pl[0] ^ {c[N-2:0], carry_q};
  assign unused_pl = ^pl[LVL];

  always_comb begin
    sum_d = sum_q;
    for (int k = 0; k < CHUNKS; k++)
      if (idx_q == CW'(k)) sum_d[k*N +: N] = s;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)  state_d = RUN;
      RUN:     if (last)        state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid_i) begin
        a_q     <= a_i;
        b_q     <= b_i;
        carry_q <= cin_i;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        sum_q   <= sum_d;
        carry_q <= c[N-1];
        if (last) begin
          cout_q <= c[N-1];
          idx_q  <= '0;
        end else begin
          idx_q  <= idx_q + 1'b1;
        end
      end
    end
  end

`ifdef KSA_SEQ_FLAGS_EN
  logic zero_q, ovf_q;
  // Carry into the MSB is c[N-2] of the last chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == RUN && last) begin
      zero_q <= (sum_d == '0);
      ovf_q  <= c[N-2] ^ c[N-1];
    end
  end
  assign zero_o = zero_q;
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_ks_chunk_add_seq.sv
// Bench for ks_chunk_add_seq: directed handshake/timing scenarios on N=4/W=16, plus random
// traffic on N=4/W=16, N=8/W=32 and N=4/W=4 checked against plain a+b+cin arithmetic.
`timescale 1ns/1ps
module tb_ks_chunk_add_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  iv, ir, ov, orr, ci, co;
  logic [15:0] a0, b0, s0;
  logic [31:0] a1, b1, s1;
  logic [3:0]  a2, b2, s2;
`ifdef KSA_SEQ_FLAGS_EN
  logic [2:0]  zf, vf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ks_chunk_add_seq #(.N(4), .W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]), .a_i(a0), .b_i(b0),
    .cin_i(ci[0]), .out_valid_o(ov[0]), .out_ready_i(orr[0]), .sum_o(s0), .cout_o(co[0])
`ifdef KSA_SEQ_FLAGS_EN
    , .zero_o(zf[0]), .ovf_o(vf[0])
`endif
  );

  ks_chunk_add_seq #(.N(8), .W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]), .a_i(a1), .b_i(b1),
    .cin_i(ci[1]), .out_valid_o(ov[1]), .out_ready_i(orr[1]), .sum_o(s1), .cout_o(co[1])
`ifdef KSA_SEQ_FLAGS_EN
    , .zero_o(zf[1]), .ovf_o(vf[1])
`endif
  );

  ks_chunk_add_seq #(.N(4), .W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[2]), .in_ready_o(ir[2]), .a_i(a2), .b_i(b2),
    .cin_i(ci[2]), .out_valid_o(ov[2]), .out_ready_i(orr[2]), .sum_o(s2), .cout_o(co[2])
`ifdef KSA_SEQ_FLAGS_EN
    , .zero_o(zf[2]), .ovf_o(vf[2])
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offer one operand set to DUT0 and return 1ns after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    a0 = a; b0 = b; ci[0] = c; iv[0] = 1'b1;
    for (int k = 0; k < 20 && !ir[0]; k++) step;
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_op_ready_timeout in_ready=%b want 1", ir[0]);
    end
    step;
    iv[0] = 1'b0;
    a0 = '0; b0 = '0;
  endtask

  task automatic drain0;
    iv[0] = 1'b0; orr[0] = 1'b1;
    for (int k = 0; k < 20 && !(ir[0] && !ov[0]); k++) step;
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL drain_idle_timeout in_ready=%b want 1", ir[0]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) step;
    rst_n = 1'b1;
    #2;
    checks++;
    if (ir !== 3'b111) begin errors++; $display("FAIL reset_in_ready got %b want 111", ir); end
    checks++;
    if (ov !== 3'b000) begin errors++; $display("FAIL reset_out_valid got %b want 000", ov); end
    checks++;
    if ({s0, s1, s2} !== 52'd0) begin
      errors++; $display("FAIL reset_sum got %h %h %h want 0", s0, s1, s2);
    end
    checks++;
    if (co !== 3'b000) begin errors++; $display("FAIL reset_cout got %b want 000", co); end
`ifdef KSA_SEQ_FLAGS_EN
    checks++;
    if ({zf, vf} !== 6'd0) begin errors++; $display("FAIL reset_flags got %b%b want 0", zf, vf); end
`endif
    step;
  endtask

  task automatic test_basic;
    logic early;
    orr[0] = 1'b1;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    early = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ov[0] !== 1'b0) early = 1'b1;
      step;
    end
    checks++;
    if (early) begin errors++; $display("FAIL basic_latency out_valid before 4 edges"); end
    checks++;
    if (ov[0] !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", ov[0]); end
    checks++;
    if ({co[0], s0} !== 17'h1_0000) begin
      errors++; $display("FAIL basic_result got %b_%h want 1_0000", co[0], s0);
    end
    step;
    checks++;
    if ({ir[0], ov[0]} !== 2'b10) begin
      errors++; $display("FAIL basic_return_idle ready/valid=%b want 10", {ir[0], ov[0]});
    end
  endtask

  task automatic test_back_to_back;
    int first, second, nres;
    first = -1; second = -1; nres = 0;
    a0 = 16'h1234; b0 = 16'h4321; ci[0] = 1'b1; iv[0] = 1'b1; orr[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (iv[0] && ir[0]) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (ov[0] && orr[0]) begin
        nres++;
        checks++;
        if ({co[0], s0} !== 17'h0_5556) begin
          errors++; $display("FAIL b2b_result got %b_%h want 0_5556", co[0], s0);
        end
      end
      step;
    end
    checks++;
    if (first < 0 || second < 0 || second - first != 6) begin
      errors++; $display("FAIL b2b_interval got %0d want 6", second - first);
    end
    checks++;
    if (nres < 2) begin errors++; $display("FAIL b2b_result_count got %0d want >=2", nres); end
    drain0;
  endtask

  task automatic test_backpressure;
    orr[0] = 1'b0;
    start_op(16'hABCD, 16'h1111, 1'b0);
    repeat (4) step;
    for (int k = 0; k < 5; k++) begin
      a0 = 16'($urandom); b0 = 16'($urandom); iv[0] = 1'b1;
      checks++;
      if ({ov[0], ir[0], co[0], s0} !== {3'b100, 16'hBCDE}) begin
        errors++;
        $display("FAIL bp_hold valid=%b ready=%b cout=%b sum=%h want 1 0 0 bcde", ov[0], ir[0], co[0], s0);
      end
      step;
    end
    iv[0] = 1'b0; orr[0] = 1'b1;
    step;
    checks++;
    if ({ir[0], ov[0], s0} !== {2'b10, 16'hBCDE}) begin
      errors++; $display("FAIL bp_release ready=%b valid=%b sum=%h want 1 0 bcde", ir[0], ov[0], s0);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    orr[0] = 1'b1;
    start_op(16'h0F0F, 16'h0101, 1'b1);
    repeat (2) step;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov[0], co[0], s0} !== 18'd0) begin
      errors++; $display("FAIL midreset_outputs valid=%b cout=%b sum=%h want 0", ov[0], co[0], s0);
    end
`ifdef KSA_SEQ_FLAGS_EN
    checks++;
    if ({zf[0], vf[0]} !== 2'b00) begin errors++; $display("FAIL midreset_flags got %b%b want 00", zf[0], vf[0]); end
`endif
    step;
    rst_n = 1'b1;
    #2;
    checks++;
    if (ir[0] !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", ir[0]); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ov[0] !== 1'b0) seen = 1'b1;
      step;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_no_output out_valid seen after reset"); end
  endtask

`ifdef KSA_SEQ_FLAGS_EN
  task automatic test_flags;
    orr[0] = 1'b0;
    start_op(16'h7FFF, 16'h0001, 1'b0);
    repeat (4) step;
    checks++;
    if ({s0, vf[0], zf[0], co[0]} !== {16'h8000, 3'b100}) begin
      errors++; $display("FAIL flags_pos_ovf sum=%h ovf=%b zero=%b cout=%b want 8000 1 0 0", s0, vf[0], zf[0], co[0]);
    end
    orr[0] = 1'b1;
    step;
    orr[0] = 1'b0;
    start_op(16'h8000, 16'h8000, 1'b0);
    repeat (4) step;
    checks++;
    if ({s0, vf[0], zf[0], co[0]} !== {16'h0000, 3'b111}) begin
      errors++; $display("FAIL flags_neg_ovf sum=%h ovf=%b zero=%b cout=%b want 0000 1 1 1", s0, vf[0], zf[0], co[0]);
    end
    drain0;
  endtask
`endif

  task automatic test_random;
    logic [34:0] q0[$], q1[$], q2[$];
    logic [34:0] exp, got;
    logic [31:0] pa[3], pb[3], mask, sv, gs;
    logic [63:0] full;
    logic        gz, gv;
    int          wd, nops[3];
    nops = '{0, 0, 0};
    for (int t = 0; t < 30000; t++) begin
      for (int d = 0; d < 3; d++) begin
        wd   = (d == 0) ? 16 : (d == 1) ? 32 : 4;
        mask = (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
        if (t < 29940) begin
          iv[d]  = ($urandom_range(0, 3) != 0);
          orr[d] = ($urandom_range(0, 3) != 0);
        end else begin
          iv[d] = 1'b0; orr[d] = 1'b1;
        end
        pa[d] = $urandom & mask;
        pb[d] = $urandom & mask;
        ci[d] = 1'($urandom_range(0, 1));
      end
      a0 = pa[0][15:0]; b0 = pb[0][15:0];
      a1 = pa[1];       b1 = pb[1];
      a2 = pa[2][3:0];  b2 = pb[2][3:0];
      #0;
      for (int d = 0; d < 3; d++) begin
        wd   = (d == 0) ? 16 : (d == 1) ? 32 : 4;
        mask = (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
        if (ov[d] && orr[d]) begin
          gs = (d == 0) ? {16'd0, s0} : (d == 1) ? s1 : {28'd0, s2};
          gz = 1'b0; gv = 1'b0;
`ifdef KSA_SEQ_FLAGS_EN
          gz = zf[d]; gv = vf[d];
`endif
          got = {gv, gz, co[d], gs};
          exp = 35'h7_FFFF_FFFF;
          if (d == 0 && q0.size() > 0) exp = q0.pop_front();
          if (d == 1 && q1.size() > 0) exp = q1.pop_front();
          if (d == 2 && q2.size() > 0) exp = q2.pop_front();
          checks++;
          if (got !== exp) begin
            errors++; $display("FAIL rand_result dut%0d got %h want %h", d, got, exp);
          end
        end
        if (iv[d] && ir[d]) begin
          full = 64'(pa[d]) + 64'(pb[d]) + 64'(ci[d]);
          sv   = full[31:0] & mask;
          exp  = {2'b00, full[wd], sv};
`ifdef KSA_SEQ_FLAGS_EN
          exp[33] = (sv == 32'd0);
          exp[34] = (pa[d][wd-1] == pb[d][wd-1]) && (sv[wd-1] != pa[d][wd-1]);
`endif
          nops[d]++;
          if (d == 0) q0.push_back(exp);
          if (d == 1) q1.push_back(exp);
          if (d == 2) q2.push_back(exp);
        end
      end
      step;
    end
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++; $display("FAIL rand_pending got %0d/%0d/%0d want 0", q0.size(), q1.size(), q2.size());
    end
    checks++;
    if (nops[0] < 100 || nops[1] < 100 || nops[2] < 100) begin
      errors++; $display("FAIL rand_op_count got %0d/%0d/%0d want >=100", nops[0], nops[1], nops[2]);
    end
  endtask

  initial begin
    iv = '0; orr = '1; ci = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
`ifdef KSA_SEQ_FLAGS_EN
    test_flags;
`endif
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
